// File: rtl/vjtag_byte_link_pkg.sv
// vjtag_byte_link_pkg
//   Shared definitions for the VirtualJTAG byte-link endpoint:
//   - PAD_BYTE_DEFAULT : byte returned to the host when the TX FIFO is empty
//   - tx_state_e       : TX load FSM encoding (IDLE=1'b0, LOAD=1'b1)
package vjtag_byte_link_pkg;

  localparam logic [7:0] PAD_BYTE_DEFAULT = 8'h00;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_LOAD = 1'b1
  } tx_state_e;

endpackage

// File: rtl/vjtag_byte_link_if.sv
// vjtag_byte_link_if
//   User-side byte streams of the VirtualJTAG link.
//   rx_* : link -> user (show-ahead head, popped on rx_valid & rx_ready)
//   tx_* : user -> link (pushed on tx_valid & tx_ready)
//   modport master : user logic
//   modport slave  : vjtag_byte_link
interface vjtag_byte_link_if;

  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;

  modport master (
    input  rx_valid, rx_data, tx_ready,
    output rx_ready, tx_valid, tx_data
  );

  modport slave (
    output rx_valid, rx_data, tx_ready,
    input  rx_ready, tx_valid, tx_data
  );

endinterface

// File: rtl/vjtag_byte_link_byte_fifo.sv
// byte_fifo
//   Synchronous show-ahead byte FIFO, depth 2**DEPTH_LOG2.
//   Ports:
//     m_clock, p_reset_n : clock, async active-low reset (empties the FIFO)
//     push, din          : write din when push and there is room
//     pop                : advance head when pop and not empty
//     full, empty        : occupancy status
//     dout               : current head (valid while !empty)
//   A push on a full FIFO is accepted when a pop happens on the same edge.
module byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       m_clock,
  input  logic       p_reset_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] dout
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;

  logic push_ok;
  logic pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_COUNT);
  assign pop_ok  = pop & ~empty;
  // When full, the slot being written is the head being popped this edge;
  // the head was already read combinationally, so the overwrite is safe.
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr_reg];

  // Storage carries no reset: only the pointers/count define its contents.
  always_ff @(posedge m_clock) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers are exactly DEPTH_LOG2 bits, so increments wrap modulo depth.
  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/vjtag_byte_link.sv
// vjtag_byte_link
//   User-side endpoint of the VirtualJTAG byte channel (m_clock side of vjtag_uart).
//   Host->FPGA bytes (recv) are buffered in an RX FIFO; host read requests (send)
//   are answered from a TX FIFO, or with PAD_BYTE when it is empty.
//   Ports:
//     m_clock, p_reset_n     : clock, async active-low reset
//     init_recv, recv,
//     recv_data              : host write session open / byte received
//     init_send, send        : host read session open / next byte requested
//     send_set, send_data    : one-cycle strobe with the byte for the host
//     user (slave modport)   : rx/tx valid-ready user streams
//     rx_overflow            : sticky, a received byte was dropped (RX full)
//     tx_underrun            : sticky, PAD_BYTE was sent (TX empty)
//     clr_status             : clears both sticky flags (a same-edge event wins)
module vjtag_byte_link
  import vjtag_byte_link_pkg::*;
#(
  parameter int         RX_DEPTH_LOG2 = 4,
  parameter int         TX_DEPTH_LOG2 = 4,
  parameter logic [7:0] PAD_BYTE      = PAD_BYTE_DEFAULT
) (
  input  logic             m_clock,
  input  logic             p_reset_n,
  input  logic             init_recv,
  input  logic             recv,
  input  logic [7:0]       recv_data,
  input  logic             init_send,
  input  logic             send,
  output logic             send_set,
  output logic [7:0]       send_data,
  vjtag_byte_link_if.slave user,
  output logic             rx_overflow,
  output logic             tx_underrun,
  input  logic             clr_status
);

  // Opening a host write session has no effect on buffered data.
  logic unused_init_recv;
  assign unused_init_recv = init_recv;

  logic       rx_full, rx_empty, rx_pop;
  logic [7:0] rx_dout;
  logic       tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0] tx_dout;

  tx_state_e  state_reg;
  logic       pending_reg;
  logic       send_set_reg;
  logic [7:0] send_data_reg;
  logic       rx_overflow_reg;
  logic       tx_underrun_reg;
  logic       service;

  // ---------------- RX path ----------------
  assign rx_pop        = ~rx_empty & user.rx_ready;
  assign user.rx_valid = ~rx_empty;
  assign user.rx_data  = rx_dout;

  byte_fifo #(.DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
    .m_clock   (m_clock),
    .p_reset_n (p_reset_n),
    .push      (recv),
    .din       (recv_data),
    .pop       (rx_pop),
    .full      (rx_full),
    .empty     (rx_empty),
    .dout      (rx_dout)
  );

  // ---------------- TX path ----------------
  assign user.tx_ready = ~tx_full;
  assign tx_push       = user.tx_valid & ~tx_full;

  // A byte is loaded from IDLE on a fresh send, or on a send that arrived
  // during LOAD (pending) unless a new read session is opening right now.
  assign service = (state_reg == TX_IDLE) & (send | (pending_reg & ~init_send));
  assign tx_pop  = service & ~tx_empty;

  byte_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .m_clock   (m_clock),
    .p_reset_n (p_reset_n),
    .push      (tx_push),
    .din       (user.tx_data),
    .pop       (tx_pop),
    .full      (tx_full),
    .empty     (tx_empty),
    .dout      (tx_dout)
  );

  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      state_reg     <= TX_IDLE;
      pending_reg   <= 1'b0;
      send_set_reg  <= 1'b0;
      send_data_reg <= PAD_BYTE;
    end else begin
      send_set_reg <= 1'b0;
      case (state_reg)
        TX_IDLE: begin
          if (service) begin
            state_reg     <= TX_LOAD;
            send_set_reg  <= 1'b1;
            send_data_reg <= tx_empty ? PAD_BYTE : tx_dout;
            pending_reg   <= 1'b0;
          end else if (init_send) begin
            pending_reg   <= 1'b0;
          end
        end
        TX_LOAD: begin
          state_reg <= TX_IDLE;
          // Only one request can be queued behind the strobe in flight.
          if (send) begin
            pending_reg <= 1'b1;
          end else if (init_send) begin
            pending_reg <= 1'b0;
          end
        end
        default: state_reg <= TX_IDLE;
      endcase
    end
  end

  // Sticky status: an error event on the same edge as clr_status wins.
  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      rx_overflow_reg <= 1'b0;
      tx_underrun_reg <= 1'b0;
    end else begin
      if (recv & rx_full & ~rx_pop) begin
        rx_overflow_reg <= 1'b1;
      end else if (clr_status) begin
        rx_overflow_reg <= 1'b0;
      end
      if (service & tx_empty) begin
        tx_underrun_reg <= 1'b1;
      end else if (clr_status) begin
        tx_underrun_reg <= 1'b0;
      end
    end
  end

  assign send_set    = send_set_reg;
  assign send_data   = send_data_reg;
  assign rx_overflow = rx_overflow_reg;
  assign tx_underrun = tx_underrun_reg;

endmodule
